// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes and a registered result/zero/tag.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts; the default build shifts iteratively.

package alu_exec_pkg;
    localparam logic [3:0] ALU_ADD    = 4'h0;
    localparam logic [3:0] ALU_SUB    = 4'h1;
    localparam logic [3:0] ALU_AND    = 4'h2;
    localparam logic [3:0] ALU_OR     = 4'h3;
    localparam logic [3:0] ALU_XOR    = 4'h4;
    localparam logic [3:0] ALU_SLT    = 4'h5;
    localparam logic [3:0] ALU_SLTU   = 4'h6;
    localparam logic [3:0] ALU_SLL    = 4'h7;
    localparam logic [3:0] ALU_SRL    = 4'h8;
    localparam logic [3:0] ALU_SRA    = 4'h9;
    localparam logic [3:0] ALU_COPY_B = 4'hA;
    localparam logic [3:0] ALU_XXX    = 4'hF;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shift_kind_e;
endpackage

module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_aluop,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_HOLD
    } state_e;

    state_e           r_state;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_result;
    logic             r_zero;
    logic [TAG_W-1:0] r_tag;

    logic             w_accept;
    logic             w_start_shift;
    logic [4:0]       w_shamt;
    logic [XLEN-1:0]  w_alu_result;

    assign w_shamt  = in_b[4:0];
    assign in_ready = !flush && ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready));
    assign w_accept = in_valid && in_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_alu_result = '0;
        case (in_aluop)
            ALU_ADD:    w_alu_result = in_a + in_b;
            ALU_SUB:    w_alu_result = in_a - in_b;
            ALU_AND:    w_alu_result = in_a & in_b;
            ALU_OR:     w_alu_result = in_a | in_b;
            ALU_XOR:    w_alu_result = in_a ^ in_b;
            ALU_SLT:    w_alu_result = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            ALU_SLTU:   w_alu_result = {{(XLEN-1){1'b0}}, in_a < in_b};
            ALU_COPY_B: w_alu_result = in_b;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL:    w_alu_result = in_a << w_shamt;
            ALU_SRL:    w_alu_result = in_a >> w_shamt;
            ALU_SRA:    w_alu_result = $signed(in_a) >>> w_shamt;
`else
            // Only reached with shamt == 0; non-zero amounts go through the iterative path.
            ALU_SLL, ALU_SRL, ALU_SRA: w_alu_result = in_a;
`endif
            default:    w_alu_result = '0;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN
    assign w_start_shift = 1'b0;
`else
    localparam logic [5:0] STEP = 6'(SHIFT_STEP);

    logic [XLEN-1:0] r_sh_val;
    logic [5:0]      r_sh_rem;
    shift_kind_e     r_sh_kind;

    logic [5:0]      w_step;
    logic            w_sh_last;
    logic [XLEN-1:0] w_sh_next;
    shift_kind_e     w_kind;

    assign w_start_shift = ((in_aluop == ALU_SLL) || (in_aluop == ALU_SRL) ||
                            (in_aluop == ALU_SRA)) && (w_shamt != 5'd0);
    assign w_kind        = (in_aluop == ALU_SLL) ? SH_SLL :
                           (in_aluop == ALU_SRL) ? SH_SRL : SH_SRA;
    assign w_step        = (r_sh_rem > STEP) ? STEP : r_sh_rem;
    assign w_sh_last     = (r_sh_rem <= STEP);

    always_comb begin
        w_sh_next = r_sh_val;
        case (r_sh_kind)
            SH_SLL:  w_sh_next = r_sh_val << w_step;
            SH_SRL:  w_sh_next = r_sh_val >> w_step;
            SH_SRA:  w_sh_next = $signed(r_sh_val) >>> w_step;
            default: w_sh_next = r_sh_val;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: outputs are cleared asynchronously so nothing stale is visible during or after reset.
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_tag       <= '0;
`ifndef ALU_BARREL_SHIFT_EN
            r_sh_val    <= '0;
            r_sh_rem    <= '0;
            r_sh_kind   <= SH_SLL;
`endif
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_accept) begin
                        r_tag <= in_tag;
                        if (w_start_shift) begin
                            r_state     <= S_SHIFT;
                            r_out_valid <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
                            r_sh_val    <= in_a;
                            r_sh_rem    <= {1'b0, w_shamt};
                            r_sh_kind   <= w_kind;
`endif
                        end else begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                            r_result    <= w_alu_result;
                            r_zero      <= (w_alu_result == '0);
                        end
                    end else if ((r_state == S_HOLD) && out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                S_SHIFT: begin
`ifdef ALU_BARREL_SHIFT_EN
                    r_state <= S_IDLE;
`else
                    r_sh_val <= w_sh_next;
                    r_sh_rem <= r_sh_rem - w_step;
                    if (w_sh_last) begin
                        r_state     <= S_HOLD;
                        r_out_valid <= 1'b1;
                        r_result    <= w_sh_next;
                        r_zero      <= (w_sh_next == '0);
                    end
`endif
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_zero   = r_zero;
    assign out_tag    = r_tag;

endmodule
